video_ts_render: RTL

//  TS renderer: sits directly downstream of the tile/sprite processing unit (video_ts).

---
 rtl/video_ts_render_if.sv | 34 +++
 rtl/video_ts_render.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/video_ts_render_if.sv
// video_ts_render_if: bundles the TS renderer's task, DRAM and line-buffer signals.
// Ports: start/tsr_* (task in, tsr_rdy out), dram_* (word fetch), ts_* (line-buffer write).
// slave = renderer side, master = upstream/memory/line-buffer side.
interface video_ts_render_if;
  logic        start;
  logic        tsr_go;
  logic [5:0]  tsr_addr;
  logic [8:0]  tsr_line;
  logic [7:0]  tsr_page;
  logic [8:0]  tsr_x;
  logic [2:0]  tsr_xs;
  logic        tsr_xf;
  logic [3:0]  tsr_pal;
  logic        tsr_rdy;
  logic [20:0] dram_addr;
  logic        dram_req;
  logic        dram_next;
  logic [15:0] dram_rdata;
  logic [8:0]  ts_waddr;
  logic [7:0]  ts_wdata;
  logic        ts_we;

  modport slave (
    input  start, tsr_go, tsr_addr, tsr_line, tsr_page, tsr_x, tsr_xs, tsr_xf, tsr_pal,
    input  dram_next, dram_rdata,
    output tsr_rdy, dram_addr, dram_req, ts_waddr, ts_wdata, ts_we
  );

  modport master (
    output start, tsr_go, tsr_addr, tsr_line, tsr_page, tsr_x, tsr_xs, tsr_xf, tsr_pal,
    output dram_next, dram_rdata,
    input  tsr_rdy, dram_addr, dram_req, ts_waddr, ts_wdata, ts_we
  );
endinterface

// File: rtl/video_ts_render.sv
// video_ts_render: fetches 4bpp tile/sprite words from DRAM and writes opaque pixels to the TS line buffer.
// Ports: clk, rst_n (async active-low), bus (video_ts_render_if.slave: task, DRAM, line-buffer write).
// Optional macro TSR_CLIP_EN: suppress line-buffer writes at X >= LINE_VIS.
module video_ts_render #(
  parameter int BUF_WORDS = 2,
  parameter int LINE_VIS  = 360
) (
  input  logic             clk,
  input  logic             rst_n,
  video_ts_render_if.slave bus
);
  localparam int AW = (BUF_WORDS > 2) ? $clog2(BUF_WORDS) : 1;
  localparam logic [AW:0] BUF_FULL = (AW+1)'(BUF_WORDS);
  localparam logic [9:0]  VIS_LIM  = 10'(LINE_VIS);
`ifdef TSR_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [8:0]    line_q, line_d;
  logic [7:0]    page_q, page_d;
  logic [2:0]    xs_q, xs_d;
  logic          xf_q, xf_d;
  logic [3:0]    pal_q, pal_d;
  logic [6:0]    wptr_q, wptr_d;
  logic [4:0]    fcnt_q, fcnt_d;
  logic          req_q, req_d;
  logic [15:0]   mem_q [BUF_WORDS];
  logic [15:0]   mem_d [BUF_WORDS];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [15:0]   sh_q, sh_d;
  logic [2:0]    slots_q, slots_d;
  logic [8:0]    x_q, x_d;
  logic          we_q, we_d;
  logic [8:0]    waddr_q, waddr_d;
  logic [7:0]    wdata_q, wdata_d;

  logic [4:0] n_words;
  logic [7:0] page_sum;
  logic       push, pop;
  logic [3:0] pix;

  assign n_words  = ({2'b0, xs_q} + 5'd1) << 1;
  assign page_sum = page_q + {5'b0, line_q[8:6]};
  // req_q can only be high when the buffer had room, so a strobe is never lost.
  assign push     = (state_q == ST_FETCH) && req_q && bus.dram_next;
  // Unpacker takes a new word only once all 4 slots of the previous one are spent.
  assign pop      = (slots_q == 3'd0) && (cnt_q != '0);
  assign pix      = sh_q[15:12];

  assign bus.tsr_rdy   = (state_q == ST_IDLE);
  assign bus.dram_req  = req_q;
  assign bus.dram_addr = {page_sum, line_q[5:0], wptr_q};
  assign bus.ts_we     = we_q;
  assign bus.ts_waddr  = waddr_q;
  assign bus.ts_wdata  = wdata_q;

  always_comb begin
    state_d  = state_q;
    line_d   = line_q;
    page_d   = page_q;
    xs_d     = xs_q;
    xf_d     = xf_q;
    pal_d    = pal_q;
    wptr_d   = wptr_q;
    fcnt_d   = fcnt_q;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    sh_d     = sh_q;
    slots_d  = slots_q;
    x_d      = x_q;
    we_d     = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.tsr_go) begin
          line_d  = bus.tsr_line;
          page_d  = bus.tsr_page;
          xs_d    = bus.tsr_xs;
          xf_d    = bus.tsr_xf;
          pal_d   = bus.tsr_pal;
          wptr_d  = {bus.tsr_addr, 1'b0};
          fcnt_d  = 5'd0;
          // Flipped slices start at the right edge: x + W - 1.
          x_d     = bus.tsr_xf ? (bus.tsr_x + {3'b0, bus.tsr_xs, 3'b111}) : bus.tsr_x;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (push) begin
          wptr_d = wptr_q + 7'd1;
          fcnt_d = fcnt_q + 5'd1;
          if (fcnt_d == n_words) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if ((cnt_q == '0) && (slots_q == 3'd0)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (push) begin
      mem_d[wr_ptr_q] = bus.dram_rdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end

    if (pop) begin
      sh_d     = mem_q[rd_ptr_q];
      slots_d  = 3'd4;
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else if (slots_q != 3'd0) begin
      // Transparent pixels still consume their X position.
      we_d    = (pix != 4'd0) && (!CLIP_EN || ({1'b0, x_q} < VIS_LIM));
      waddr_d = x_q;
      wdata_d = {pal_q, pix};
      sh_d    = {sh_q[11:0], 4'd0};
      slots_d = slots_q - 3'd1;
      x_d     = xf_q ? (x_q - 9'd1) : (x_q + 9'd1);
    end

    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    req_d = (state_d == ST_FETCH) && (cnt_d != BUF_FULL);

    // Line start aborts everything; a go in the same cycle is discarded.
    if (bus.start) begin
      state_d  = ST_IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      slots_d  = 3'd0;
      fcnt_d   = 5'd0;
      req_d    = 1'b0;
      we_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      line_q   <= '0;
      page_q   <= '0;
      xs_q     <= '0;
      xf_q     <= 1'b0;
      pal_q    <= '0;
      wptr_q   <= '0;
      fcnt_q   <= '0;
      req_q    <= 1'b0;
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      sh_q     <= '0;
      slots_q  <= '0;
      x_q      <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      line_q   <= line_d;
      page_q   <= page_d;
      xs_q     <= xs_d;
      xf_q     <= xf_d;
      pal_q    <= pal_d;
      wptr_q   <= wptr_d;
      fcnt_q   <= fcnt_d;
      req_q    <= req_d;
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      slots_q  <= slots_d;
      x_q      <= x_d;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end
endmodule
